// File: rtl/pio_edge_capture.sv
// pio_edge_capture
//   Input-conditioning front end for a PIO input path. Raw pins are synchronised,
//   optionally debounced, and the clean level is driven on stable_out. Edges on the
//   clean level are latched in a sticky edge-capture register that raises irq when
//   the matching mask bit is set. An Avalon-MM slave exposes DATA (addr 0),
//   IRQ_MASK (addr 2) and EDGE_CAP (addr 3, write-1-to-clear).
//
//   Build option: define PIO_EDGE_DEBOUNCE_EN to include the per-bit debounce
//   counters. Without it the synchronised sample is registered straight onto
//   stable_out and DEBOUNCE_CYCLES is ignored.
//
// Ports
//   clk         system clock
//   reset_n     asynchronous active-low reset
//   in_port     raw asynchronous pin inputs
//   address     word address
//   chipselect  slave select
//   write_n     active-low write strobe
//   writedata   write data, bits [WIDTH-1:0] used
//   readdata    registered read data, zero-extended, one clock read latency
//   stable_out  clean (debounced) level
//   irq         level interrupt, active high, registered
`timescale 1ns/1ps
module pio_edge_capture #(
  parameter int WIDTH           = 8,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int EDGE_TYPE       = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [WIDTH-1:0]  in_port,
  input  logic [2:0]        address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic [WIDTH-1:0]  stable_out,
  output logic              irq
);

  localparam logic [1:0] EDGE_SEL = 2'(EDGE_TYPE);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_r;
  logic [WIDTH-1:0] sample_s;
  logic [WIDTH-1:0] stable_r;
  logic [WIDTH-1:0] stable_nxt_s;
  logic [WIDTH-1:0] stable_d_r;
  logic [WIDTH-1:0] edge_s;
  logic [WIDTH-1:0] mask_r;
  logic [WIDTH-1:0] mask_nxt_s;
  logic [WIDTH-1:0] cap_r;
  logic [WIDTH-1:0] cap_nxt_s;
  logic [WIDTH-1:0] clr_s;
  logic [31:0]      readdata_r;
  logic [31:0]      rd_nxt_s;
  logic             irq_r;
  logic             wr_s;
  logic             unused_wdata_s;

  assign sample_s       = sync_r[SYNC_STAGES-1];
  assign wr_s           = chipselect & ~write_n;
  assign unused_wdata_s = &{1'b0, writedata};

  // Synchroniser shift chain; stage 0 takes the raw pins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_r <= '0;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], in_port};
    end
  end

`ifdef PIO_EDGE_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0][CNT_W-1:0] cnt_r;
  logic [WIDTH-1:0][CNT_W-1:0] cnt_nxt_s;

  // Per-bit debounce: count consecutive cycles the sample differs from the clean
  // level; the Nth such cycle commits the new level. Any return restarts at 0.
  // The >= compare keeps the counter from ever wrapping.
  always_comb begin
    cnt_nxt_s    = cnt_r;
    stable_nxt_s = stable_r;
    for (int i = 0; i < WIDTH; i++) begin
      if (sample_s[i] == stable_r[i]) begin
        cnt_nxt_s[i] = '0;
      end else if (cnt_r[i] >= CNT_LAST) begin
        stable_nxt_s[i] = sample_s[i];
        cnt_nxt_s[i]    = '0;
      end else begin
        cnt_nxt_s[i] = cnt_r[i] + CNT_W'(1);
      end
    end
  end

  // Debounce counter state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_r <= '0;
    end else begin
      cnt_r <= cnt_nxt_s;
    end
  end
`else
  // No debounce: the clean level simply follows the synchronised sample.
  always_comb begin
    stable_nxt_s = sample_s;
  end
`endif

  // Edge detection on the clean level against its one-clock-delayed copy.
  always_comb begin
    case (EDGE_SEL)
      2'd0:    edge_s = stable_r & ~stable_d_r;
      2'd1:    edge_s = ~stable_r & stable_d_r;
      default: edge_s = stable_r ^ stable_d_r;
    endcase
  end

  // Register-file next state. A new edge overrides a W1C clear on the same bit.
  always_comb begin
    if (wr_s && (address == 3'd2)) begin
      mask_nxt_s = writedata[WIDTH-1:0];
    end else begin
      mask_nxt_s = mask_r;
    end
    if (wr_s && (address == 3'd3)) begin
      clr_s = writedata[WIDTH-1:0];
    end else begin
      clr_s = '0;
    end
    cap_nxt_s = (cap_r & ~clr_s) | edge_s;
  end

  // Read mux, evaluated every clock regardless of chipselect.
  always_comb begin
    rd_nxt_s = 32'd0;
    case (address)
      3'd0:    rd_nxt_s[WIDTH-1:0] = stable_r;
      3'd2:    rd_nxt_s[WIDTH-1:0] = mask_r;
      3'd3:    rd_nxt_s[WIDTH-1:0] = cap_r;
      default: rd_nxt_s = 32'd0;
    endcase
  end

  // State registers; irq is decoded from capture and mask flops only.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stable_r   <= '0;
      stable_d_r <= '0;
      mask_r     <= '0;
      cap_r      <= '0;
      readdata_r <= 32'd0;
      irq_r      <= 1'b0;
    end else begin
      stable_r   <= stable_nxt_s;
      stable_d_r <= stable_r;
      mask_r     <= mask_nxt_s;
      cap_r      <= cap_nxt_s;
      readdata_r <= rd_nxt_s;
      irq_r      <= |(cap_r & mask_r);
    end
  end

  assign readdata   = readdata_r;
  assign stable_out = stable_r;
  assign irq        = irq_r;

endmodule
